// File: rtl/edge_mesh_check_pkg.sv
// edge_mesh_check_pkg: shared render types, defaults and edge/arith helpers
package edge_mesh_check_pkg;
  localparam int DEF_COORD_W = 21;
  localparam int DEF_NUM_VTX = 4;
  localparam int DEF_NUM_EDGES = 6;
  localparam int DEF_VIDX_W = 2;
  localparam int DEF_EIDX_W = 3;
  localparam logic [23:0] DEF_EDGE_LIST = 24'hED9C84;
  localparam int DEF_THICK = 1;
  typedef logic signed [DEF_COORD_W-1:0] coord_t;
  typedef logic signed [63:0] wide_t;
  function automatic int edge_vtx(input logic [255:0] list, input int e, input int vidx_w, input logic b);
    logic [255:0] s;
    s = list >> (e * 2 * vidx_w + (b ? vidx_w : 0));
    return int'(s[31:0] & ((32'd1 << vidx_w) - 32'd1));
  endfunction
  function automatic wide_t abs_w(input wide_t a);
    return a < 0 ? -a : a;
  endfunction
  function automatic wide_t max_w(input wide_t a, input wide_t b);
    return a > b ? a : b;
  endfunction
  function automatic wide_t min_w(input wide_t a, input wide_t b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/edge_mesh_check_if.sv
// edge_mesh_check_if: vertex write, commit, pixel stream and hit result bundle
interface edge_mesh_check_if import edge_mesh_check_pkg::*; #(
  parameter int COORD_W = DEF_COORD_W,
  parameter int VIDX_W = DEF_VIDX_W,
  parameter int NUM_EDGES = DEF_NUM_EDGES,
  parameter int EIDX_W = DEF_EIDX_W
);
  logic vtx_wr_en;
  logic [VIDX_W-1:0] vtx_wr_idx;
  logic signed [COORD_W-1:0] vtx_wr_x;
  logic signed [COORD_W-1:0] vtx_wr_y;
  logic commit;
  logic in_valid;
  logic signed [COORD_W-1:0] h_cnt_Q;
  logic signed [COORD_W-1:0] v_cnt_Q;
  logic out_valid;
  logic [NUM_EDGES-1:0] onLine;
  logic any_hit;
  logic [EIDX_W-1:0] hit_idx;
  modport master (
    output vtx_wr_en, vtx_wr_idx, vtx_wr_x, vtx_wr_y, commit, in_valid, h_cnt_Q, v_cnt_Q,
    input out_valid, onLine, any_hit, hit_idx
  );
  modport slave (
    input vtx_wr_en, vtx_wr_idx, vtx_wr_x, vtx_wr_y, commit, in_valid, h_cnt_Q, v_cnt_Q,
    output out_valid, onLine, any_hit, hit_idx
  );
endinterface

// File: rtl/edge_mesh_check_edge_test_pipe.sv
// edge_test_pipe: one edge's 3-stage point-on-thick-segment test
module edge_test_pipe import edge_mesh_check_pkg::*; #(
  parameter int COORD_W = DEF_COORD_W,
  parameter int THICK = DEF_THICK
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [COORD_W-1:0] px,
  input  logic signed [COORD_W-1:0] py,
  input  logic signed [COORD_W-1:0] ax,
  input  logic signed [COORD_W-1:0] ay,
  input  logic signed [COORD_W-1:0] bx,
  input  logic signed [COORD_W-1:0] by,
  input  logic v2,
  output logic on_d,
  output logic on_q
);
  localparam int DW = COORD_W + 1;
  localparam int BW = COORD_W + 2;
  localparam int CW = 2 * COORD_W + 3;
  logic signed [COORD_W-1:0] px_q, py_q, ax_q, ay_q, bx_q, by_q;
  logic signed [COORD_W-1:0] px_d, py_d, ax_d, ay_d, bx_d, by_d;
  logic signed [DW-1:0] dx_q, dy_q, dx_d, dy_d, ex, ey;
  logic signed [CW-1:0] cross_q, cross_d, lim_q, lim_d;
  logic signed [BW-1:0] lo_x, hi_x, lo_y, hi_y, pbx, pby;
  logic box_q, box_d;
  always_comb begin
    px_d = px;
    py_d = py;
    ax_d = ax;
    ay_d = ay;
    bx_d = bx;
    by_d = by;
    dx_d = DW'(bx) - DW'(ax);
    dy_d = DW'(by) - DW'(ay);
    ex = DW'(px_q) - DW'(ax_q);
    ey = DW'(py_q) - DW'(ay_q);
    cross_d = CW'(ex) * CW'(dy_q) - CW'(ey) * CW'(dx_q);
    lim_d = CW'(wide_t'(THICK) * max_w(abs_w(64'(dx_q)), abs_w(64'(dy_q))));
    lo_x = BW'(min_w(64'(ax_q), 64'(bx_q))) - BW'(THICK);
    hi_x = BW'(max_w(64'(ax_q), 64'(bx_q))) + BW'(THICK);
    lo_y = BW'(min_w(64'(ay_q), 64'(by_q))) - BW'(THICK);
    hi_y = BW'(max_w(64'(ay_q), 64'(by_q))) + BW'(THICK);
    pbx = BW'(px_q);
    pby = BW'(py_q);
    box_d = (pbx >= lo_x) && (pbx <= hi_x) && (pby >= lo_y) && (pby <= hi_y);
    on_d = v2 && box_q && (abs_w(64'(cross_q)) <= 64'(lim_q));
  end
  always_ff @(posedge clk) begin
    px_q <= px_d;
    py_q <= py_d;
    ax_q <= ax_d;
    ay_q <= ay_d;
    bx_q <= bx_d;
    by_q <= by_d;
    dx_q <= dx_d;
    dy_q <= dy_d;
    cross_q <= cross_d;
    lim_q <= lim_d;
    box_q <= box_d;
    on_q <= rst ? on_d : 1'b0;
  end
endmodule

// File: rtl/edge_mesh_check.sv
// edge_mesh_check: double-buffered vertex bank feeding per-edge hit pipelines
module edge_mesh_check import edge_mesh_check_pkg::*; #(
  parameter int COORD_W = DEF_COORD_W,
  parameter int NUM_VTX = DEF_NUM_VTX,
  parameter int NUM_EDGES = DEF_NUM_EDGES,
  parameter int VIDX_W = DEF_VIDX_W,
  parameter int EIDX_W = DEF_EIDX_W,
  parameter logic [2*VIDX_W*NUM_EDGES-1:0] EDGE_LIST = DEF_EDGE_LIST,
  parameter int THICK = DEF_THICK
) (
  input logic CLK,
  input logic rst,
  edge_mesh_check_if.slave bus
);
  typedef logic signed [COORD_W-1:0] crd_t;
  crd_t sx_q[NUM_VTX], sy_q[NUM_VTX], sx_d[NUM_VTX], sy_d[NUM_VTX];
  crd_t vx_q[NUM_VTX], vy_q[NUM_VTX], vx_d[NUM_VTX], vy_d[NUM_VTX];
  logic [2:0] vld_q, vld_d;
  logic [NUM_EDGES-1:0] on_d, on_q;
  logic any_hit_q, any_hit_d;
  logic [EIDX_W-1:0] hit_idx_q, hit_idx_d;
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    vx_d = vx_q;
    vy_d = vy_q;
    if (bus.commit) begin
      vx_d = sx_q;
      vy_d = sy_q;
    end
    if (bus.vtx_wr_en && int'(bus.vtx_wr_idx) < NUM_VTX) begin
      sx_d[bus.vtx_wr_idx] = bus.vtx_wr_x;
      sy_d[bus.vtx_wr_idx] = bus.vtx_wr_y;
    end
    vld_d = {vld_q[1:0], bus.in_valid};
    any_hit_d = |on_d;
    hit_idx_d = '0;
    for (int i = NUM_EDGES - 1; i >= 0; i--) if (on_d[i]) hit_idx_d = EIDX_W'(i);
  end
  always_ff @(posedge CLK) begin
    if (!rst) begin
      sx_q <= '{default: '0};
      sy_q <= '{default: '0};
      vx_q <= '{default: '0};
      vy_q <= '{default: '0};
      vld_q <= '0;
      any_hit_q <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
      vld_q <= vld_d;
      any_hit_q <= any_hit_d;
      hit_idx_q <= hit_idx_d;
    end
  end
  // every pipe samples the active bank on the pixel's S1 edge, so a commit never splits a pixel
  for (genvar e = 0; e < NUM_EDGES; e++) begin : g_edge
    localparam int VA = edge_vtx(256'(EDGE_LIST), e, VIDX_W, 1'b0);
    localparam int VB = edge_vtx(256'(EDGE_LIST), e, VIDX_W, 1'b1);
    edge_test_pipe #(.COORD_W(COORD_W), .THICK(THICK)) u_pipe (
      .clk(CLK),
      .rst(rst),
      .px(bus.h_cnt_Q),
      .py(bus.v_cnt_Q),
      .ax(vx_q[VA]),
      .ay(vy_q[VA]),
      .bx(vx_q[VB]),
      .by(vy_q[VB]),
      .v2(vld_q[1]),
      .on_d(on_d[e]),
      .on_q(on_q[e])
    );
  end
  assign bus.out_valid = vld_q[2];
  assign bus.onLine = on_q;
  assign bus.any_hit = any_hit_q;
  assign bus.hit_idx = hit_idx_q;
endmodule

// File: tb/tb_edge_mesh_check.sv
// tb_edge_mesh_check: directed checks of edge_mesh_check with a streaming reference model
module tb_edge_mesh_check;
  import edge_mesh_check_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int vx[4], vy[4];
  logic [5:0] expq[$];
  always #5 clk = ~clk;
  edge_mesh_check_if bus ();
  edge_mesh_check dut (.CLK(clk), .rst(rst), .bus(bus));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [5:0] m, input logic [2:0] idx);
    chk({tag, " valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, " onLine"}, 32'(bus.onLine), 32'(m));
    chk({tag, " any_hit"}, 32'(bus.any_hit), 32'(|m));
    chk({tag, " hit_idx"}, 32'(bus.hit_idx), 32'(idx));
  endtask
  task automatic wr(input int idx, input int x, input int y);
    bus.vtx_wr_en = 1'b1;
    bus.vtx_wr_idx = 2'(idx);
    bus.vtx_wr_x = coord_t'(x);
    bus.vtx_wr_y = coord_t'(y);
    tick;
    bus.vtx_wr_en = 1'b0;
  endtask
  task automatic cmt;
    bus.commit = 1'b1;
    tick;
    bus.commit = 1'b0;
  endtask
  task automatic pix(input int x, input int y);
    bus.in_valid = 1'b1;
    bus.h_cnt_Q = coord_t'(x);
    bus.v_cnt_Q = coord_t'(y);
    tick;
    bus.in_valid = 1'b0;
    tick;
    tick;
  endtask
  function automatic logic [5:0] model(input int px, input int py);
    int pa[6] = '{0, 0, 0, 1, 1, 2};
    int pb[6] = '{1, 2, 3, 2, 3, 3};
    logic [5:0] m;
    longint ax, ay, bx, by, dx, dy, cr, adx, ady, lim;
    m = '0;
    for (int e = 0; e < 6; e++) begin
      ax = vx[pa[e]];
      ay = vy[pa[e]];
      bx = vx[pb[e]];
      by = vy[pb[e]];
      dx = bx - ax;
      dy = by - ay;
      cr = (px - ax) * dy - (py - ay) * dx;
      if (cr < 0) cr = -cr;
      adx = dx < 0 ? -dx : dx;
      ady = dy < 0 ? -dy : dy;
      lim = adx > ady ? adx : ady;
      m[e] = (cr <= lim) && px >= (ax < bx ? ax : bx) - 1 && px <= (ax > bx ? ax : bx) + 1
             && py >= (ay < by ? ay : by) - 1 && py <= (ay > by ? ay : by) + 1;
    end
    return m;
  endfunction
  function automatic logic [2:0] low_idx(input logic [5:0] m);
    for (int i = 0; i < 6; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction
  initial begin
    logic [5:0] e;
    int px, py;
    bus.vtx_wr_en = 1'b0;
    bus.vtx_wr_idx = '0;
    bus.vtx_wr_x = '0;
    bus.vtx_wr_y = '0;
    bus.commit = 1'b0;
    bus.in_valid = 1'b0;
    bus.h_cnt_Q = '0;
    bus.v_cnt_Q = '0;
    tick;
    tick;
    chk_out("reset", 1'b0, 6'h00, 3'd0);
    rst = 1'b1;
    pix(0, 0);
    chk_out("origin", 1'b1, 6'h3F, 3'd0);
    tick;
    chk_out("idle", 1'b0, 6'h00, 3'd0);
    wr(0, 10, 10);
    wr(1, 20, 10);
    cmt;
    pix(15, 10);
    chk_out("horiz 15,10", 1'b1, 6'h01, 3'd0);
    pix(15, 11);
    chk_out("horiz 15,11", 1'b1, 6'h01, 3'd0);
    pix(15, 12);
    chk_out("horiz 15,12", 1'b1, 6'h00, 3'd0);
    pix(25, 10);
    chk_out("horiz 25,10 box", 1'b1, 6'h00, 3'd0);
    wr(0, 0, 0);
    wr(2, 8, 4);
    cmt;
    pix(4, 2);
    chk_out("diag 4,2", 1'b1, 6'h33, 3'd0);
    pix(4, 3);
    chk_out("diag 4,3", 1'b1, 6'h33, 3'd0);
    pix(4, 4);
    chk_out("diag 4,4", 1'b1, 6'h00, 3'd0);
    wr(0, 5, 5);
    wr(3, 5, 5);
    cmt;
    pix(6, 6);
    chk_out("degen 6,6", 1'b1, 6'h15, 3'd0);
    pix(7, 5);
    chk_out("degen 7,5", 1'b1, 6'h33, 3'd0);
    pix(8, 3);
    chk_out("degen 8,3 prio", 1'b1, 6'h2A, 3'd1);
    wr(0, 10, 10);
    wr(1, 20, 10);
    wr(2, 0, 0);
    wr(3, 0, 0);
    cmt;
    pix(15, 10);
    chk_out("atom base", 1'b1, 6'h01, 3'd0);
    wr(1, 100, 100);
    pix(15, 10);
    chk_out("atom no commit", 1'b1, 6'h01, 3'd0);
    bus.vtx_wr_en = 1'b1;
    bus.vtx_wr_idx = 2'd0;
    bus.vtx_wr_x = coord_t'(50);
    bus.vtx_wr_y = coord_t'(50);
    cmt;
    bus.vtx_wr_en = 1'b0;
    pix(55, 55);
    chk_out("atom commit+wr", 1'b1, 6'h19, 3'd0);
    bus.in_valid = 1'b1;
    bus.h_cnt_Q = coord_t'(30);
    bus.v_cnt_Q = coord_t'(30);
    cmt;
    tick;
    bus.in_valid = 1'b0;
    tick;
    chk_out("inflight old bank", 1'b1, 6'h19, 3'd0);
    tick;
    chk_out("after commit new bank", 1'b1, 6'h1E, 3'd1);
    bus.in_valid = 1'b1;
    bus.h_cnt_Q = coord_t'(55);
    bus.v_cnt_Q = coord_t'(55);
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk_out("midreset", 1'b0, 6'h00, 3'd0);
    rst = 1'b1;
    bus.h_cnt_Q = '0;
    bus.v_cnt_Q = '0;
    tick;
    chk_out("post reset 1", 1'b0, 6'h00, 3'd0);
    tick;
    chk_out("post reset 2", 1'b0, 6'h00, 3'd0);
    tick;
    chk_out("post reset origin", 1'b1, 6'h3F, 3'd0);
    bus.in_valid = 1'b0;
    tick;
    wr(0, -10, -6);
    wr(1, 10, -6);
    wr(2, 0, 8);
    wr(3, -3, -1);
    cmt;
    vx = '{-10, 10, 0, -3};
    vy = '{-6, -6, 8, -1};
    for (int i = 0; i < 68; i++) begin
      if (i < 64) begin
        px = ((i * 7) % 29) - 14;
        py = ((i * 5) % 23) - 8;
        bus.in_valid = 1'b1;
        bus.h_cnt_Q = coord_t'(px);
        bus.v_cnt_Q = coord_t'(py);
        expq.push_back(model(px, py));
      end else begin
        bus.in_valid = 1'b0;
      end
      tick;
      chk("thr valid", 32'(bus.out_valid), 32'(i >= 2 && i < 66));
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          chk("thr queue", 32'(expq.size()), 32'd1);
        end else begin
          e = expq.pop_front();
          chk("thr onLine", 32'(bus.onLine), 32'(e));
          chk("thr any_hit", 32'(bus.any_hit), 32'(|e));
          chk("thr hit_idx", 32'(bus.hit_idx), 32'(low_idx(e)));
        end
      end
    end
    chk("thr drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/edge_mesh_check.md
Name: edge_mesh_check

Overview:
- Parametrised successor to the fixed six-edge line checker in the render pipeline.
- Holds NUM_VTX screen-space vertices in a double-buffered register bank and tests each incoming pixel against NUM_EDGES edges, with the edge list set by parameter.
- Edge test is pipelined with a fixed latency of 3 cycles. Output is a per-edge hit mask, an any-hit flag and the lowest hit index, all feeding the pixel colour mux.
- Vertex updates are staged in a shadow bank and committed atomically, typically at vblank.

Parameters:
- COORD_W, 21: signed coordinate width.
- NUM_VTX, 4: vertex count.
- NUM_EDGES, 6: edge count.
- VIDX_W, 2: vertex index width, equal to clog2(NUM_VTX).
- EIDX_W, 3: edge index width, equal to clog2(NUM_EDGES).
- EDGE_LIST, 24'hED9C84: packed edge table.
  - Edge e occupies bits [e*2*VIDX_W +: 2*VIDX_W]; vertex A is in the low VIDX_W bits, vertex B in the high bits.
  - Default is the full tetrahedron: (0,1) (0,2) (0,3) (1,2) (1,3) (2,3).
- THICK, 1: unsigned line half-width tolerance in pixels.

Ports:
- CLK  in  1  clock.
- rst  in  1  reset, synchronous and active-low.
- vtx_wr_en  in  1  write strobe into the shadow bank.
- vtx_wr_idx  in  VIDX_W  vertex index to write.
- vtx_wr_x  in  COORD_W  signed X.
- vtx_wr_y  in  COORD_W  signed Y.
- commit  in  1  single-cycle pulse: copy the shadow bank into the active bank.
- in_valid  in  1  pixel valid.
- h_cnt_Q  in  COORD_W  signed pixel X.
- v_cnt_Q  in  COORD_W  signed pixel Y.
- out_valid  out  1  result valid.
- onLine  out  NUM_EDGES  per-edge hit mask.
- any_hit  out  1  OR of onLine.
- hit_idx  out  EIDX_W  lowest set bit of onLine; 0 when there is no hit.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Shadow and active banks are cleared to (0,0).
  - All pipeline valid bits are cleared; out_valid, onLine, any_hit and hit_idx are 0 on the next cycle.
  - In-flight pixels are discarded.
  - After reset, pixel (0,0) hits every edge, because all edges are degenerate at the origin. This is intended.
- Shadow write: when vtx_wr_en=1, shadow[vtx_wr_idx] takes {x,y} at the clock edge. If vtx_wr_idx >= NUM_VTX the write is ignored.
- Commit:
  - active <= shadow, using the shadow contents as they were before this edge.
  - A write in the same cycle as commit lands in the shadow bank only; it reaches the active bank at the next commit.
  - commit with no prior writes is harmless.
- Pipeline: 3 cycles, no backpressure, one pixel per cycle.
  - S1: register P, per-edge A and B from the active bank, dx=Bx-Ax and dy=By-Ay (COORD_W+1 bits each). Each pixel is evaluated entirely with the vertex bank that was active on its S1 cycle, so a commit mid-stream never mixes banks within one pixel.
  - S2, per edge:
    - cross = (Px-Ax)*dy - (Py-Ay)*dx, signed, 2*COORD_W+3 bits, no overflow possible.
    - lim = THICK*max(|dx|,|dy|).
    - Bounding box: min(Ax,Bx)-THICK <= Px <= max(Ax,Bx)+THICK, and the same in Y. Compare at COORD_W+2 bits.
  - S3: onLine[e] = (|cross| <= lim) AND in_box. Also register any_hit and a priority-encoded hit_idx.
- out_valid is in_valid delayed by 3 cycles. When out_valid=0, onLine, any_hit and hit_idx are 0.
- Degenerate edge (A==B): cross=0 and lim=0, so the edge hits exactly within the (2*THICK+1)-square centred on A.
- Coordinates are signed throughout; negative or off-screen vertices are legal, with no clamping.

Decomposition:
- Shared render package:
  - coordinate typedef (signed COORD_W);
  - a function to unpack an edge (EDGE_LIST, e) into its vertex pair;
  - abs/max helper functions.
- Sub-module edge_test_pipe:
  - one edge's S1–S3 datapath, without the vertex bank;
  - instantiated NUM_EDGES times via generate;
  - the top level holds the banks, the valid pipe and the priority encoder.

Test Plan:
- Horizontal edge: write v0=(10,10), v1=(20,10), commit. Pixels (15,10), (15,11), (15,12), (25,10) → 3 cycles later onLine[0] = 1, 1, 0, 0 (the last is rejected by the bounding box).
- Diagonal edge: v0=(0,0), v2=(8,4), commit. Pixels (4,2), (4,3), (4,4) → onLine[1] = 1, 1, 0, because cross = 0, -8, -16 against lim = 8.
- Degenerate edge: v0=v3=(5,5), commit. Pixels (6,6) → onLine[2]=1; (7,5) → onLine[2]=0. When several edges hit, hit_idx is the lowest index and any_hit=1.
- Commit atomicity:
  - Write v1=(100,100) without commit → the streamed result for (15,10) is unchanged.
  - Assert commit together with a write of v0=(50,50) → the active bank has the new v1 and the old v0.
  - A pixel in flight during the commit uses the old bank.
- Reset mid-stream: drive back-to-back in_valid, pull rst=0 for 1 cycle → out_valid=0 on the following cycles until fresh pixels have propagated 3 cycles. The active bank reads (0,0), so pixel (0,0) gives onLine=6'h3F.
- Throughput: 64 consecutive valid pixels → 64 consecutive out_valid cycles, in order, matching a reference model bit-exactly.
